// File: rtl/sparrow_pkg.sv
// Shared types and constants for the sparrow memory arbiter.
package sparrow_pkg;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} arb_state_e;
  typedef enum logic {OWN_IF, OWN_LS} arb_owner_e;

  localparam logic [1:0] ARB_BYTE_EN_WORD = 2'b10;

endpackage

// File: rtl/sparrow_arb_pick.sv
// Combinational requester selection for the memory arbiter.
// SPARROW_ARB_RR_EN selects round-robin tie-breaking; otherwise fixed priority LS > IF.
module sparrow_arb_pick
  import sparrow_pkg::*;
(
  input  logic       if_req,
  input  logic       ls_req,
  input  logic       lock,
  input  arb_owner_e lock_owner,
`ifdef SPARROW_ARB_RR_EN
  input  arb_owner_e last_gnt,
`endif
  output arb_owner_e owner,
  output logic       valid
);

  always_comb begin
    owner = OWN_IF;
    if (lock) begin
      owner = lock_owner;
    end else if (if_req && ls_req) begin
`ifdef SPARROW_ARB_RR_EN
      owner = (last_gnt == OWN_IF) ? OWN_LS : OWN_IF;
`else
      owner = OWN_LS;
`endif
    end else if (ls_req) begin
      owner = OWN_LS;
    end
    valid = (owner == OWN_LS) ? ls_req : if_req;
  end

endmodule

// File: rtl/sparrow_mem_arbiter.sv
// Shares one single-port memory between fetch and load/store with a response watchdog.
// Define SPARROW_ARB_RR_EN for round-robin arbitration (default: fixed priority LS > IF).
module sparrow_mem_arbiter
  import sparrow_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_ls_req,
  input  logic [31:0] i_ls_addr,
  input  logic [1:0]  i_ls_byte_en,
  input  logic        i_ls_wr_en,
  input  logic [31:0] i_ls_wr_data,
  output logic        o_ls_gnt,
  output logic        o_ls_rvalid,
  output logic [31:0] o_ls_rdata,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic [1:0]  o_mem_byte_en,
  output logic        o_mem_wr_en,
  output logic [31:0] o_mem_wr_data,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_err_timeout
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Fire on the cycle whose increment would reach TIMEOUT_CYCLES, i.e. after that many waiting cycles.
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_e    state_q, state_d;
  logic          lock_q;
  arb_owner_e    lock_owner_q;
  logic [TW-1:0] timer_q;
  arb_owner_e    sel_owner;
  logic          sel_valid;
  logic          timeout_hit;

`ifdef SPARROW_ARB_RR_EN
  arb_owner_e    rr_last_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rr_last_q <= OWN_IF;
    end else if (o_mem_req && i_mem_gnt) begin
      rr_last_q <= sel_owner;
    end
  end
`endif

  sparrow_arb_pick u_pick (
    .if_req     (i_if_req),
    .ls_req     (i_ls_req),
    .lock       (lock_q),
    .lock_owner (lock_owner_q),
`ifdef SPARROW_ARB_RR_EN
    .last_gnt   (rr_last_q),
`endif
    .owner      (sel_owner),
    .valid      (sel_valid)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TLAST);

  always_comb begin
    state_d       = state_q;
    o_mem_req     = 1'b0;
    o_mem_addr    = '0;
    o_mem_byte_en = '0;
    o_mem_wr_en   = 1'b0;
    o_mem_wr_data = '0;
    o_if_gnt      = 1'b0;
    o_ls_gnt      = 1'b0;
    o_if_rvalid   = 1'b0;
    o_if_rdata    = '0;
    o_ls_rvalid   = 1'b0;
    o_ls_rdata    = '0;
    o_err_timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Requests pass through combinationally, so reset must gate them to keep outputs low.
        if (i_reset_n && sel_valid) begin
          o_mem_req = 1'b1;
          if (sel_owner == OWN_LS) begin
            o_mem_addr    = i_ls_addr;
            o_mem_byte_en = i_ls_byte_en;
            o_mem_wr_en   = i_ls_wr_en;
            o_mem_wr_data = i_ls_wr_data;
          end else begin
            o_mem_addr    = i_if_addr;
            o_mem_byte_en = ARB_BYTE_EN_WORD;
          end
          if (i_mem_gnt) begin
            if (sel_owner == OWN_LS) begin
              o_ls_gnt = 1'b1;
              state_d  = BUSY_LS;
            end else begin
              o_if_gnt = 1'b1;
              state_d  = BUSY_IF;
            end
          end
        end
      end
      BUSY_IF: begin
        if (i_mem_rvalid) begin
          o_if_rvalid = 1'b1;
          o_if_rdata  = i_mem_rdata;
          state_d     = IDLE;
        end else if (timeout_hit) begin
          o_if_rvalid   = 1'b1;
          o_err_timeout = 1'b1;
          state_d       = IDLE;
        end
      end
      BUSY_LS: begin
        if (i_mem_rvalid) begin
          o_ls_rvalid = 1'b1;
          o_ls_rdata  = i_mem_rdata;
          state_d     = IDLE;
        end else if (timeout_hit) begin
          o_ls_rvalid   = 1'b1;
          o_err_timeout = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= IDLE;
      lock_q       <= 1'b0;
      lock_owner_q <= OWN_IF;
      timer_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        timer_q <= '0;
      end else if (!i_mem_rvalid) begin
        timer_q <= timer_q + TW'(1);
      end
      if (o_mem_req) begin
        if (i_mem_gnt) begin
          lock_q <= 1'b0;
        end else begin
          lock_q       <= 1'b1;
          lock_owner_q <= sel_owner;
        end
      end
    end
  end

endmodule

// File: tb/tb_sparrow_mem_arbiter.sv
// Directed self-checking bench for sparrow_mem_arbiter (TIMEOUT_CYCLES = 4).
module tb_sparrow_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt, o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_ls_req;
  logic [31:0] i_ls_addr;
  logic [1:0]  i_ls_byte_en;
  logic        i_ls_wr_en;
  logic [31:0] i_ls_wr_data;
  logic        o_ls_gnt, o_ls_rvalid;
  logic [31:0] o_ls_rdata;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [1:0]  o_mem_byte_en;
  logic        o_mem_wr_en;
  logic [31:0] o_mem_wr_data;
  logic        i_mem_gnt, i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_err_timeout;

  int unsigned tests = 0;
  int unsigned failed = 0;
  logic        c_first_ls;

  always #5 i_clk = ~i_clk;

  sparrow_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_if_req      (i_if_req),
    .i_if_addr     (i_if_addr),
    .o_if_gnt      (o_if_gnt),
    .o_if_rvalid   (o_if_rvalid),
    .o_if_rdata    (o_if_rdata),
    .i_ls_req      (i_ls_req),
    .i_ls_addr     (i_ls_addr),
    .i_ls_byte_en  (i_ls_byte_en),
    .i_ls_wr_en    (i_ls_wr_en),
    .i_ls_wr_data  (i_ls_wr_data),
    .o_ls_gnt      (o_ls_gnt),
    .o_ls_rvalid   (o_ls_rvalid),
    .o_ls_rdata    (o_ls_rdata),
    .o_mem_req     (o_mem_req),
    .o_mem_addr    (o_mem_addr),
    .o_mem_byte_en (o_mem_byte_en),
    .o_mem_wr_en   (o_mem_wr_en),
    .o_mem_wr_data (o_mem_wr_data),
    .i_mem_gnt     (i_mem_gnt),
    .i_mem_rvalid  (i_mem_rvalid),
    .i_mem_rdata   (i_mem_rdata),
    .o_err_timeout (o_err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    logic [31:0] acc;
    acc = {22'd0, o_if_gnt, o_if_rvalid, o_ls_gnt, o_ls_rvalid, o_mem_req,
           o_mem_byte_en, o_mem_wr_en, o_err_timeout, 1'b0};
    chk({tag, "_ctl"}, acc, 32'd0);
    chk({tag, "_data"}, o_if_rdata | o_ls_rdata | o_mem_addr | o_mem_wr_data, 32'd0);
  endtask

  initial begin
`ifdef SPARROW_ARB_RR_EN
    c_first_ls = 1'b0;
`else
    c_first_ls = 1'b1;
`endif
    i_reset_n = 1'b0;
    i_if_req = 0; i_if_addr = '0;
    i_ls_req = 0; i_ls_addr = '0; i_ls_byte_en = '0; i_ls_wr_en = 0; i_ls_wr_data = '0;
    i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
    tick(); tick();
    chk_all_zero("reset");
    i_reset_n = 1'b1;
    tick();

    // Single fetch
    i_if_req = 1; i_if_addr = 32'h1000; i_mem_gnt = 1; settle();
    chk("f_req", o_mem_req, 1);
    chk("f_addr", o_mem_addr, 32'h1000);
    chk("f_be", o_mem_byte_en, 2'b10);
    chk("f_we", o_mem_wr_en, 0);
    chk("f_if_gnt", o_if_gnt, 1);
    chk("f_ls_gnt", o_ls_gnt, 0);
    tick();
    i_if_req = 0; i_mem_gnt = 0; settle();
    chk("f_busy_req", o_mem_req, 0);
    chk("f_rv_early", o_if_rvalid, 0);
    tick();
    i_mem_rvalid = 1; i_mem_rdata = 32'hDEADBEEF; settle();
    chk("f_rv", o_if_rvalid, 1);
    chk("f_rdata", o_if_rdata, 32'hDEADBEEF);
    chk("f_ls_rv", o_ls_rvalid, 0);
    chk("f_ls_rdata", o_ls_rdata, 0);
    tick();
    i_mem_rvalid = 0; settle();
    chk("f_rv_end", o_if_rvalid, 0);
    chk("f_rdata_end", o_if_rdata, 0);

    // Tie: LS store wins first
    i_if_req = 1; i_if_addr = 32'h1000;
    i_ls_req = 1; i_ls_addr = 32'h2000; i_ls_wr_en = 1; i_ls_wr_data = 32'h55; i_ls_byte_en = 2'b01;
    i_mem_gnt = 1; settle();
    chk("t_ls_gnt", o_ls_gnt, 1);
    chk("t_if_gnt", o_if_gnt, 0);
    chk("t_addr", o_mem_addr, 32'h2000);
    chk("t_we", o_mem_wr_en, 1);
    chk("t_wd", o_mem_wr_data, 32'h55);
    chk("t_be", o_mem_byte_en, 2'b01);
    tick();
    i_ls_req = 0; i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = 0; settle();
    chk("t_busy_req", o_mem_req, 0);
    chk("t_ls_rv", o_ls_rvalid, 1);
    chk("t_if_rv", o_if_rvalid, 0);
    tick();
    // Second tie: round-robin picks IF, fixed priority picks LS again
    i_ls_req = 1; i_ls_addr = 32'h2004; i_ls_wr_en = 0; i_ls_wr_data = 0;
    i_mem_rvalid = 0; i_mem_gnt = 1; settle();
    chk("t2_ls_gnt", o_ls_gnt, c_first_ls);
    chk("t2_if_gnt", o_if_gnt, !c_first_ls);
    chk("t2_addr", o_mem_addr, c_first_ls ? 32'h2004 : 32'h1000);
    tick();
    if (c_first_ls) i_ls_req = 0; else i_if_req = 0;
    i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = 32'hA5A5A5A5; settle();
    chk("t2_ls_rv", o_ls_rvalid, c_first_ls);
    chk("t2_if_rv", o_if_rvalid, !c_first_ls);
    tick();
    i_mem_rvalid = 0; i_mem_gnt = 1; settle();
    chk("t3_ls_gnt", o_ls_gnt, !c_first_ls);
    chk("t3_if_gnt", o_if_gnt, c_first_ls);
    tick();
    i_if_req = 0; i_ls_req = 0; i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = 32'h0F0F0F0F; settle();
    chk("t3_ls_rv", o_ls_rvalid, !c_first_ls);
    chk("t3_ls_rdata", o_ls_rdata, !c_first_ls ? 32'h0F0F0F0F : 32'h0);
    chk("t3_if_rdata", o_if_rdata, c_first_ls ? 32'h0F0F0F0F : 32'h0);
    tick();
    i_mem_rvalid = 0;

    // Lock: IF held un-granted while LS arrives
    i_if_req = 1; i_if_addr = 32'h3000; i_mem_gnt = 0; settle();
    chk("l0_req", o_mem_req, 1);
    chk("l0_addr", o_mem_addr, 32'h3000);
    tick();
    i_ls_req = 1; i_ls_addr = 32'h4000; i_ls_wr_en = 0; i_ls_byte_en = 2'b10; settle();
    chk("l1_addr", o_mem_addr, 32'h3000);
    chk("l1_ls_gnt", o_ls_gnt, 0);
    tick(); settle();
    chk("l2_addr", o_mem_addr, 32'h3000);
    tick();
    i_mem_gnt = 1; settle();
    chk("l3_if_gnt", o_if_gnt, 1);
    chk("l3_ls_gnt", o_ls_gnt, 0);
    chk("l3_addr", o_mem_addr, 32'h3000);
    tick();
    i_if_req = 0; i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = 32'h11; settle();
    chk("l4_if_rv", o_if_rvalid, 1);
    chk("l4_if_rdata", o_if_rdata, 32'h11);
    tick();
    i_mem_rvalid = 0; i_mem_gnt = 1; settle();
    chk("l5_ls_gnt", o_ls_gnt, 1);
    chk("l5_addr", o_mem_addr, 32'h4000);
    tick();
    i_ls_req = 0; i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = 32'h22; settle();
    chk("l6_ls_rdata", o_ls_rdata, 32'h22);
    tick();
    i_mem_rvalid = 0;

    // Watchdog on an LS load
    i_ls_req = 1; i_ls_addr = 32'h5000; i_mem_gnt = 1; settle();
    chk("w_gnt", o_ls_gnt, 1);
    tick();
    i_ls_req = 0; i_mem_gnt = 0; i_mem_rdata = 32'hFFFFFFFF;
    for (int i = 1; i <= 3; i++) begin
      settle();
      chk("w_wait_rv", o_ls_rvalid, 0);
      chk("w_wait_err", o_err_timeout, 0);
      tick();
    end
    settle();
    chk("w_err", o_err_timeout, 1);
    chk("w_rv", o_ls_rvalid, 1);
    chk("w_rdata", o_ls_rdata, 0);
    tick();
    i_mem_rvalid = 1; settle();
    chk("w_late_ls", o_ls_rvalid, 0);
    chk("w_late_if", o_if_rvalid, 0);
    chk("w_late_err", o_err_timeout, 0);
    tick();
    i_mem_rvalid = 0; i_if_req = 1; i_if_addr = 32'h6000; i_mem_gnt = 1; settle();
    chk("w_if_gnt", o_if_gnt, 1);
    tick();
    i_if_req = 0; i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = 32'hCAFE0001; settle();
    chk("w_if_rdata", o_if_rdata, 32'hCAFE0001);
    chk("w_if_err", o_err_timeout, 0);
    tick();
    i_mem_rvalid = 0;

    // rvalid coinciding with the timeout cycle
    i_if_req = 1; i_if_addr = 32'h7000; i_mem_gnt = 1; tick();
    i_if_req = 0; i_mem_gnt = 0;
    tick(); tick(); tick();
    i_mem_rvalid = 1; i_mem_rdata = 32'hBEEF0004; settle();
    chk("rt_rv", o_if_rvalid, 1);
    chk("rt_rdata", o_if_rdata, 32'hBEEF0004);
    chk("rt_err", o_err_timeout, 0);
    tick();
    i_mem_rvalid = 0;

    // Async reset while BUSY_LS
    i_ls_req = 1; i_ls_addr = 32'h8000; i_mem_gnt = 1; tick();
    i_ls_req = 0; i_mem_gnt = 0; i_if_req = 1; i_if_addr = 32'h9000;
    i_mem_rvalid = 1; i_mem_rdata = 32'h12345678;
    #2;
    i_reset_n = 1'b0; settle();
    chk_all_zero("ar");
    tick();
    i_if_req = 0; settle();
    i_reset_n = 1'b1;
    tick(); settle();
    chk("ar_no_ls_rv", o_ls_rvalid, 0);
    chk("ar_no_if_rv", o_if_rvalid, 0);
    i_mem_rvalid = 0;
    i_if_req = 1; i_ls_req = 1; i_mem_gnt = 1; settle();
    chk("ar_tie_ls", o_ls_gnt, 1);
    chk("ar_tie_if", o_if_gnt, 0);
    tick();
    i_if_req = 0; i_ls_req = 0; i_mem_gnt = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
